// File: rtl/fifo_wm.sv
// Single-clock FIFO with exact occupancy, watermarks, synchronous flush and sticky error flags.
// Supports any depth from 1 upward and an optional fall-through path when empty.
module fifo_wm #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned AF_THRESH    = DEPTH - 1,
  parameter int unsigned AE_THRESH    = 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  err_clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  alm_full_o,
  output logic                  alm_empty_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LastIdx = PW'(DEPTH - 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  pass_through, push_eff, pop_eff, wr_en;
  logic                  ovf_evt, udf_evt;
  logic [DATA_WIDTH-1:0] head;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign usage_o     = count_q;
  assign alm_full_o  = (count_q >= CNT_W'(AF_THRESH));
  assign alm_empty_o = (count_q <= CNT_W'(AE_THRESH));
  assign ovf_o       = ovf_q;
  assign udf_o       = udf_q;

  // An empty fall-through FIFO hands the word straight to a same-cycle pop.
  assign pass_through = FALL_THROUGH && empty_o && push_i && pop_i;
  assign pop_eff      = pop_i && !empty_o;
  assign push_eff     = push_i && (!full_o || pop_eff) && !pass_through;
  assign wr_en        = push_eff && !flush_i;
  assign ovf_evt      = push_i && full_o && !pop_eff && !flush_i;
  assign udf_evt      = pop_i && empty_o && !pass_through && !flush_i;

  assign data_o = (FALL_THROUGH && empty_o && push_i) ? data_i : head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PW'(1);
      if (pop_eff)  rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PW'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // A fresh error in the clearing cycle takes priority.
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  if (DEPTH == 1) begin : g_single
    logic [DATA_WIDTH-1:0] mem_q;
    always_ff @(posedge clk_i) begin
      if (wr_en) mem_q <= data_i;
    end
    assign head = mem_q;
  end else begin : g_multi
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end
    assign head = mem_q[rd_ptr_q];
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (DEPTH >= 1) else $error("fifo_wm: DEPTH must be >= 1");
    assert (AF_THRESH >= 1 && AF_THRESH <= DEPTH) else $error("fifo_wm: AF_THRESH out of range");
    assert (AE_THRESH < DEPTH) else $error("fifo_wm: AE_THRESH out of range");
    if (!rst_i) begin
      assert (count_q <= CNT_W'(DEPTH)) else $error("fifo_wm: count exceeds DEPTH");
    end
  end
`endif

endmodule
